// File: rtl/id_hazard_fwd_unit.sv
// ID-stage hazard detection and forwarding select unit with a multi-cycle stall FSM.
// Optional stall-cycle counter output when ID_HAZARD_STALL_CNT_EN is defined.
module id_hazard_fwd_unit #(
   parameter int NUM_SRC   = 2,
   parameter int ADDR_W    = 5,
   parameter int MAX_STALL = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic                      id_is_branch,
   input  logic                      id_flush,
   input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic [ADDR_W-1:0]         ex_rd,
   input  logic                      ex_reg_write,
   input  logic                      ex_mem_read,
   input  logic [ADDR_W-1:0]         ex_m_rd,
   input  logic                      ex_m_reg_write,
   input  logic                      ex_m_mem_read,
   input  logic [ADDR_W-1:0]         m_rd,
   input  logic                      m_reg_write,
   output logic [2*NUM_SRC-1:0]      forward_sel,
   output logic                      stall
`ifdef ID_HAZARD_STALL_CNT_EN
   ,
   output logic [15:0]               stall_cnt
`endif
);

   localparam int CNT_W = $clog2(MAX_STALL + 1);
   localparam int NW    = (CNT_W > 2) ? CNT_W : 2;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [NUM_SRC-1:0] hit_ex, hit_exm, hit_wb;
   logic               need2, need1;
   logic [NW-1:0]      n_req, n_clip;

   always_comb begin
      hit_ex  = '0;
      hit_exm = '0;
      hit_wb  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         hit_ex[k]  = id_src_used[k] && ex_reg_write && (ex_rd != '0)
                      && (id_src_addr[k*ADDR_W +: ADDR_W] == ex_rd);
         hit_exm[k] = id_src_used[k] && ex_m_reg_write && (ex_m_rd != '0)
                      && (id_src_addr[k*ADDR_W +: ADDR_W] == ex_m_rd);
         hit_wb[k]  = id_src_used[k] && m_reg_write && (m_rd != '0)
                      && (id_src_addr[k*ADDR_W +: ADDR_W] == m_rd);
      end
   end

   always_comb begin
      forward_sel = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (hit_exm[k])
            forward_sel[2*k +: 2] = 2'b01;
         else if (hit_wb[k])
            forward_sel[2*k +: 2] = 2'b10;
      end
   end

   // Max required stall over all ports collapses to two any-port flags.
   always_comb begin
      need2 = id_valid && id_is_branch && (|hit_ex) && ex_mem_read;
      need1 = id_valid && (id_is_branch
              ? ((|hit_ex) || ((|hit_exm) && ex_m_mem_read))
              : ((|hit_ex) && ex_mem_read));
      n_req = need2 ? NW'(2) : (need1 ? NW'(1) : '0);
      n_clip = (n_req > NW'(MAX_STALL)) ? NW'(MAX_STALL) : n_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (id_flush) begin
         state_d = IDLE;
         rem_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (n_clip >= NW'(2)) begin
                  state_d = STALL;
                  rem_d   = CNT_W'(n_clip - NW'(1));
               end
            end
            STALL: begin
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1))
                  state_d = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stall = 1'b0;
      unique case (1'b1)
         id_flush:                      stall = 1'b0;
         !id_flush && state_q == STALL: stall = 1'b1;
         default:                       stall = (n_clip != '0);
      endcase
   end

`ifdef ID_HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Bench for id_hazard_fwd_unit: default instance plus NUM_SRC=3/MAX_STALL=1 instance.
// Behavioural owed-cycle model checked every negedge, plus directed literal checks.
module tb_id_hazard_fwd_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_is_branch, id_flush;
   logic [14:0] a3;
   logic [2:0]  u3;
   logic [4:0]  ex_rd, ex_m_rd, m_rd;
   logic        ex_reg_write, ex_mem_read;
   logic        ex_m_reg_write, ex_m_mem_read, m_reg_write;
   logic [3:0]  fsel2;
   logic [5:0]  fsel3;
   logic        stall2, stall3;
`ifdef ID_HAZARD_STALL_CNT_EN
   logic [15:0] scnt2, scnt3;
   int          mcnt2 = 0, mcnt3 = 0;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_hazard_fwd_unit u_dut2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_is_branch(id_is_branch), .id_flush(id_flush),
      .id_src_addr(a3[9:0]), .id_src_used(u3[1:0]),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_m_rd(ex_m_rd), .ex_m_reg_write(ex_m_reg_write),
      .ex_m_mem_read(ex_m_mem_read),
      .m_rd(m_rd), .m_reg_write(m_reg_write),
      .forward_sel(fsel2), .stall(stall2)
`ifdef ID_HAZARD_STALL_CNT_EN
      , .stall_cnt(scnt2)
`endif
   );

   id_hazard_fwd_unit #(.NUM_SRC(3), .ADDR_W(5), .MAX_STALL(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_is_branch(id_is_branch), .id_flush(id_flush),
      .id_src_addr(a3), .id_src_used(u3),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_m_rd(ex_m_rd), .ex_m_reg_write(ex_m_reg_write),
      .ex_m_mem_read(ex_m_mem_read),
      .m_rd(m_rd), .m_reg_write(m_reg_write),
      .forward_sel(fsel3), .stall(stall3)
`ifdef ID_HAZARD_STALL_CNT_EN
      , .stall_cnt(scnt3)
`endif
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- behavioural model ----
   function automatic bit src_hit(int k, logic [4:0] rd, logic we);
      logic [4:0] s;
      s = a3[k*5 +: 5];
      return u3[k] && we && rd != 5'd0 && s == rd;
   endfunction

   function automatic int req_n(int num, int max_st);
      int n, nk;
      n = 0;
      if (!id_valid) return 0;
      for (int k = 0; k < num; k++) begin
         nk = 0;
         if (id_is_branch) begin
            if (src_hit(k, ex_rd, ex_reg_write))
               nk = ex_mem_read ? 2 : 1;
            else if (src_hit(k, ex_m_rd, ex_m_reg_write) && ex_m_mem_read)
               nk = 1;
         end else if (src_hit(k, ex_rd, ex_reg_write) && ex_mem_read) begin
            nk = 1;
         end
         if (nk > n) n = nk;
      end
      return (n > max_st) ? max_st : n;
   endfunction

   function automatic logic [5:0] fsel_m(int num);
      logic [5:0] f;
      f = '0;
      for (int k = 0; k < num; k++) begin
         if (src_hit(k, ex_m_rd, ex_m_reg_write)) f[2*k +: 2] = 2'b01;
         else if (src_hit(k, m_rd, m_reg_write)) f[2*k +: 2] = 2'b10;
      end
      return f;
   endfunction

   int owed2 = 0, owed3 = 0, next2 = 0, next3 = 0;
   bit e2 = 0, e3 = 0;

   function automatic void step_model(int n, int owed, output bit e, output int nx);
      if (id_flush) begin
         e = 0; nx = 0;
      end else if (owed > 0) begin
         e = 1; nx = owed - 1;
      end else begin
         e = (n > 0); nx = (n > 0) ? n - 1 : 0;
      end
      if (!rst_n) nx = 0;
   endfunction

   always @(negedge clk) begin
      logic [5:0] f2, f3;
      step_model(req_n(2, 2), owed2, e2, next2);
      step_model(req_n(3, 1), owed3, e3, next3);
      f2 = fsel_m(2);
      f3 = fsel_m(3);
      chk("model_stall2", stall2, e2);
      chk("model_stall3", stall3, e3);
      chk("model_fsel2", fsel2, f2[3:0]);
      chk("model_fsel3", fsel3, f3);
`ifdef ID_HAZARD_STALL_CNT_EN
      chk("model_cnt2", scnt2, mcnt2);
      chk("model_cnt3", scnt3, mcnt3);
`endif
   end

   always @(posedge clk) begin
      if (rst_n) begin
         owed2 = next2;
         owed3 = next3;
`ifdef ID_HAZARD_STALL_CNT_EN
         if (e2) mcnt2++;
         if (e3) mcnt3++;
`endif
      end
   end

   always @(negedge rst_n) begin
      owed2 = 0; owed3 = 0; next2 = 0; next3 = 0;
`ifdef ID_HAZARD_STALL_CNT_EN
      mcnt2 = 0; mcnt3 = 0;
`endif
   end

   // ---- directed stimulus ----
   task automatic clr();
      id_valid = 1'b1; id_is_branch = 1'b0; id_flush = 1'b0;
      a3 = '0; u3 = '0;
      ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      ex_m_rd = '0; ex_m_reg_write = 1'b0; ex_m_mem_read = 1'b0;
      m_rd = '0; m_reg_write = 1'b0;
   endtask

   task automatic setp(int k, logic [4:0] r);
      a3[k*5 +: 5] = r;
      u3[k] = 1'b1;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      rst_n = 1'b0;
      nxt();
      #1;
      chk("reset_stall", stall2, 1'b0);
      chk("reset_fsel", fsel2, 4'b0000);
      nxt();
      rst_n = 1'b1;

      // forwarding priority
      nxt(); clr(); setp(0, 5'd3);
      ex_m_rd = 5'd3; ex_m_reg_write = 1'b1; m_rd = 5'd3; m_reg_write = 1'b1;
      #1 chk("fwd_exm_wins", fsel2[1:0], 2'b01);
      nxt(); ex_m_reg_write = 1'b0;
      #1 chk("fwd_wb_no_we", fsel2[1:0], 2'b10);
      nxt(); ex_m_reg_write = 1'b1; ex_m_rd = 5'd0;
      #1 chk("fwd_wb_rd0", fsel2[1:0], 2'b10);
      nxt(); setp(1, 5'd4); m_rd = 5'd4;
      #1 chk("fwd_two_ports", fsel2, 4'b1000);

      // non-branch load-use
      nxt(); clr(); setp(1, 5'd7);
      ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 chk("lu_stall", stall2, 1'b1);
      nxt(); clr(); setp(1, 5'd7);
      ex_m_rd = 5'd7; ex_m_reg_write = 1'b1; ex_m_mem_read = 1'b1;
      #1 chk("lu_release", stall2, 1'b0);
      chk("lu_fwd", fsel2[3:2], 2'b01);

      // invalid instruction and x0 source never stall
      nxt(); clr(); id_valid = 1'b0; setp(0, 5'd6);
      ex_rd = 5'd6; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 chk("invalid_nostall", stall2, 1'b0);
      nxt(); clr(); setp(0, 5'd0); id_is_branch = 1'b1;
      ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 chk("x0_nostall", stall2, 1'b0);

      // branch load hazard, two cycles
      nxt(); clr(); rst_n = 1'b0;
      nxt(); rst_n = 1'b1;
      nxt(); id_is_branch = 1'b1; setp(0, 5'd9);
      ex_rd = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 chk("br_ld_c1", stall2, 1'b1);
      nxt(); ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      ex_m_rd = 5'd9; ex_m_reg_write = 1'b1; ex_m_mem_read = 1'b1;
      #1 chk("br_ld_c2", stall2, 1'b1);
      nxt(); ex_m_rd = '0; ex_m_reg_write = 1'b0; ex_m_mem_read = 1'b0;
      m_rd = 5'd9; m_reg_write = 1'b1;
      #1 chk("br_ld_c3", stall2, 1'b0);
      chk("br_ld_fwd", fsel2[1:0], 2'b10);
`ifdef ID_HAZARD_STALL_CNT_EN
      chk("br_ld_cnt", scnt2, 16'd2);
`endif

      // flush in second stall cycle
      nxt(); clr(); id_is_branch = 1'b1; setp(0, 5'd9);
      ex_rd = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 chk("fl_c1", stall2, 1'b1);
      nxt(); id_flush = 1'b1; ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      ex_m_rd = 5'd9; ex_m_reg_write = 1'b1; ex_m_mem_read = 1'b1;
      #1 chk("fl_c2", stall2, 1'b0);
      nxt(); clr();
      #1 chk("fl_idle", stall2, 1'b0);

      // async reset mid-stall
      nxt(); clr(); id_is_branch = 1'b1; setp(0, 5'd9);
      ex_rd = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 chk("rs_c1", stall2, 1'b1);
      nxt(); clr();
      #1 chk("rs_c2", stall2, 1'b1);
      rst_n = 1'b0;
      #1 chk("rs_async_drop", stall2, 1'b0);
      nxt(); nxt(); rst_n = 1'b1;
      clr(); id_is_branch = 1'b1; a3[4:0] = 5'd5;
      ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      ex_m_rd = 5'd5; ex_m_reg_write = 1'b1;
      #1 chk("unused_nostall", stall2, 1'b0);
      chk("unused_fsel", fsel2, 4'b0000);

      // three-port instance, MAX_STALL=1
      nxt(); clr(); id_is_branch = 1'b1; setp(2, 5'd12);
      ex_rd = 5'd12; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 chk("p2_stall3", stall3, 1'b1);
      chk("p2_stall2", stall2, 1'b0);
      chk("p2_sel_c1", fsel3[5:4], 2'b00);
      nxt(); ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      ex_m_rd = 5'd12; ex_m_reg_write = 1'b1;
      #1 chk("p2_clip_end", stall3, 1'b0);
      chk("p2_sel_c2", fsel3[5:4], 2'b01);
      nxt(); ex_m_rd = '0; ex_m_reg_write = 1'b0;
      m_rd = 5'd12; m_reg_write = 1'b1;
      #1 chk("p2_sel_c3", fsel3[5:4], 2'b10);

      nxt(); clr();
      nxt();
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
